// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one external SRAM between two req/ack ports.
// Each access is sequenced as SETUP, then WAIT_CYCLES cycles of STROBE, then DONE; all pad controls come from registers.
module sram_port_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_dout_en,
  input  logic [DATA_W-1:0] ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                last_grant_q;
  logic                sel_q;
  logic                we_q;
  logic                r0_ack_q, r1_ack_q;
  logic [DATA_W-1:0]   r0_rdata_q, r1_rdata_q;
  logic                ram_we_q, ram_oe_q, ram_dout_en_q, busy_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_dout_q;

  logic gnt_vld_d, gnt_sel_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    gnt_vld_d = r0_req | r1_req;
    gnt_sel_d = r1_req;
    if (r0_req && r1_req) gnt_sel_d = ~last_grant_q;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      r0_ack_q      <= 1'b0;
      r1_ack_q      <= 1'b0;
      r0_rdata_q    <= '0;
      r1_rdata_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_dout_en_q <= 1'b0;
      busy_q        <= 1'b0;
      ram_addr_q    <= '0;
      ram_dout_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            sel_q         <= gnt_sel_d;
            last_grant_q  <= gnt_sel_d;
            we_q          <= gnt_sel_d ? r1_we : r0_we;
            ram_addr_q    <= gnt_sel_d ? r1_addr : r0_addr;
            ram_dout_q    <= gnt_sel_d ? r1_wdata : r0_wdata;
            ram_dout_en_q <= gnt_sel_d ? r1_we : r0_we;
            busy_q        <= 1'b1;
            state_q       <= SETUP;
          end
        end
        SETUP: begin
          cnt_q    <= CNT_INIT;
          ram_we_q <= we_q;
          ram_oe_q <= ~we_q;
          state_q  <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            ram_we_q <= 1'b0;
            ram_oe_q <= 1'b0;
            state_q  <= DONE;
            // Read data is taken from the final strobe cycle.
            if (!we_q && sel_q)  r1_rdata_q <= ram_din;
            if (!we_q && !sel_q) r0_rdata_q <= ram_din;
            r1_ack_q <= sel_q;
            r0_ack_q <= ~sel_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          r0_ack_q      <= 1'b0;
          r1_ack_q      <= 1'b0;
          ram_dout_en_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_ack      = r0_ack_q;
  assign r1_ack      = r1_ack_q;
  assign r0_rdata    = r0_rdata_q;
  assign r1_rdata    = r1_rdata_q;
  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign ram_addr    = ram_addr_q;
  assign ram_dout    = ram_dout_q;
  assign ram_dout_en = ram_dout_en_q;
  assign busy        = busy_q;

endmodule
